// File: rtl/muldiv_pkg.sv
// Shared constants and types for the mul/div control sequencer:
// state encoding, ISA/ALU opcodes and IR field positions.
package muldiv_pkg;

  localparam int unsigned IR_W        = 32;
  localparam int unsigned OPC_W       = 5;
  localparam int unsigned REG_IDX_W   = 4;
  localparam int unsigned NUM_REGS    = 16;

  localparam int unsigned OPC_HI      = 31;
  localparam int unsigned OPC_LO      = 27;
  localparam int unsigned RA_HI       = 26;
  localparam int unsigned RA_LO       = 23;
  localparam int unsigned RB_HI       = 22;
  localparam int unsigned RB_LO       = 19;

  localparam logic [OPC_W-1:0] ISA_MUL = 5'b01111;
  localparam logic [OPC_W-1:0] ISA_DIV = 5'b10000;
  localparam logic [OPC_W-1:0] ALU_MUL = 5'b10001;
  localparam logic [OPC_W-1:0] ALU_DIV = 5'b10010;

  localparam int unsigned MEM_TIMEOUT = 8;
  localparam int unsigned CNT_W       = $clog2(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_e;

  function automatic logic is_legal(input logic [OPC_W-1:0] opc);
    return (opc == ISA_MUL) || (opc == ISA_DIV);
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// 4-to-16 one-hot register-out decoder; all zeros when disabled.
module reg_onehot_dec
  import muldiv_pkg::*;
(
  input  logic                 en_i,
  input  logic [REG_IDX_W-1:0] idx_i,
  output logic [NUM_REGS-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Moore control unit sequencing fetch (T0-T2) and mul/div execute (T3-T6).
// Controls decode from state and IR; mem_err is a registered timeout pulse.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 mem_ready,
  input  logic [IR_W-1:0]      IR,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 IncPC,
  output logic                 Zin,
  output logic                 ZLOout,
  output logic                 PCin,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic [NUM_REGS-1:0]  Rout,
  output logic                 Yin,
  output logic                 ZHIin,
  output logic                 ZLOin,
  output logic                 ZHIout,
  output logic                 LOin,
  output logic                 HIin,
  output logic [OPC_W-1:0]     ALU_opcode,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic                 mem_err
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mem_err_q, mem_err_d;
  logic                 rd_en;
  logic [REG_IDX_W-1:0] rd_idx;

  logic [OPC_W-1:0]     opc;
  logic [REG_IDX_W-1:0] ra;
  logic [REG_IDX_W-1:0] rb;
  logic                 unused_ir;

  assign opc       = IR[OPC_HI:OPC_LO];
  assign ra        = IR[RA_HI:RA_LO];
  assign rb        = IR[RB_HI:RB_LO];
  assign unused_ir = ^IR[RB_LO-1:0];
  assign mem_err   = mem_err_q;

  // State, T1 wait counter and timeout pulse
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_err_d  = 1'b0;
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    ZLOout     = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    ZHIin      = 1'b0;
    ZLOin      = 1'b0;
    ZHIout     = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    ALU_opcode = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    rd_en      = 1'b0;
    rd_idx     = ra;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        cnt_d   = '0;
        state_d = S_T1;
      end
      S_T1: begin
        ZLOout = 1'b1;
        PCin   = 1'b1;
        Read   = 1'b1;
        MDRin  = 1'b1;
        // mem_ready takes priority over a coincident timeout
        if (mem_ready) begin
          state_d = S_T2;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          mem_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_legal(opc)) begin
          rd_en   = 1'b1;
          rd_idx  = ra;
          Yin     = 1'b1;
          state_d = S_T4;
        end else begin
          illegal = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_T4: begin
        rd_en      = 1'b1;
        rd_idx     = rb;
        ZHIin      = 1'b1;
        ZLOin      = 1'b1;
        ALU_opcode = (opc == ISA_DIV) ? ALU_DIV : ALU_MUL;
        state_d    = S_T5;
      end
      S_T5: begin
        ZLOout  = 1'b1;
        LOin    = 1'b1;
        state_d = S_T6;
      end
      S_T6: begin
        ZHIout  = 1'b1;
        HIin    = 1'b1;
        done    = 1'b1;
        state_d = start ? S_T0 : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  reg_onehot_dec u_rout_dec (
    .en_i     (rd_en),
    .idx_i    (rd_idx),
    .onehot_o (Rout)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a small behavioural datapath
// (register file, Y, Z, LO, HI) driven by the sequencer's controls.
module tb_muldiv_sequencer;

  logic        clk, clr, start, mem_ready;
  logic [31:0] IR;
  logic        PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin;
  logic        MDRout, IRin, Yin, ZHIin, ZLOin, ZHIout, LOin, HIin;
  logic [15:0] Rout;
  logic [4:0]  ALU_opcode;
  logic        busy, done, illegal, mem_err;

  logic [15:0] ctl;
  logic [3:0]  stat;
  logic [31:0] rf [16];
  logic [31:0] bus, y, lo, hi;
  logic [63:0] z;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .ZLOout(ZLOout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Rout(Rout), .Yin(Yin),
    .ZHIin(ZHIin), .ZLOin(ZLOin), .ZHIout(ZHIout), .LOin(LOin), .HIin(HIin),
    .ALU_opcode(ALU_opcode), .busy(busy), .done(done),
    .illegal(illegal), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl  = {PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin,
                 MDRout, IRin, Yin, ZHIin, ZLOin, ZHIout, LOin, HIin};
  assign stat = {busy, done, illegal, mem_err};

  always_comb begin
    bus = '0;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus = bus | rf[i];
  end

  always @(posedge clk) begin
    if (Yin) y <= bus;
    if (ZLOin && ALU_opcode == 5'b10001) z <= 64'(y) * 64'(bus);
    if (ZLOin && ALU_opcode == 5'b10010) z <= {y % bus, y / bus};
    if (LOin) lo <= z[31:0];
    if (HIin) hi <= z[63:32];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    total++; if (ctl !== 16'h0000) begin bad++; $display("FAIL reset_ctl got=%h exp=0000", ctl); end
    total++; if (Rout !== 16'h0000) begin bad++; $display("FAIL reset_rout got=%h exp=0000", Rout); end
    total++; if (ALU_opcode !== 5'b0) begin bad++; $display("FAIL reset_alu got=%b exp=00000", ALU_opcode); end
    total++; if (stat !== 4'b0000) begin bad++; $display("FAIL reset_stat got=%b exp=0000", stat); end
    @(negedge clk);
    clr = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mul();
    logic [15:0] ectl  [8];
    logic [15:0] erout [8];
    logic [4:0]  ealu  [8];
    logic [3:0]  estat [8];
    ectl  = '{16'hF000, 16'h0F00, 16'h00C0, 16'h0020, 16'h0018, 16'h0802, 16'h0005, 16'h0000};
    erout = '{16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0080, 16'h0000, 16'h0000, 16'h0000};
    ealu  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b10001, 5'd0, 5'd0, 5'd0};
    estat = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'hC, 4'h0};
    IR = 32'h7B380000;
    mem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (ctl !== ectl[i]) begin bad++; $display("FAIL mul_ctl[%0d] got=%h exp=%h", i, ctl, ectl[i]); end
      total++; if (Rout !== erout[i]) begin bad++; $display("FAIL mul_rout[%0d] got=%h exp=%h", i, Rout, erout[i]); end
      total++; if (ALU_opcode !== ealu[i]) begin bad++; $display("FAIL mul_alu[%0d] got=%b exp=%b", i, ALU_opcode, ealu[i]); end
      total++; if (stat !== estat[i]) begin bad++; $display("FAIL mul_stat[%0d] got=%b exp=%b", i, stat, estat[i]); end
      if (i < 7) tick();
    end
    total++; if (lo !== 32'h3C) begin bad++; $display("FAIL mul_lo got=%h exp=0000003c", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL mul_hi got=%h exp=00000000", hi); end
  endtask

  task automatic test_div();
    int   n = 0;
    int   t1 = 0;
    logic got_done = 1'b0;
    logic [4:0] alu_seen = '0;
    IR = {5'b10000, 4'd2, 4'd3, 19'd0};
    mem_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      n++;
      if (Read) begin
        t1++;
        if (t1 == 4) mem_ready = 1'b1;
      end
      if (ZLOin) alu_seen = ALU_opcode;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      tick();
    end
    total++; if (got_done !== 1'b1) begin bad++; $display("FAIL div_done got=%b exp=1", got_done); end
    total++; if (n != 10) begin bad++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
    total++; if (t1 != 4) begin bad++; $display("FAIL div_t1_cycles got=%0d exp=4", t1); end
    total++; if (alu_seen !== 5'b10010) begin bad++; $display("FAIL div_alu got=%b exp=10010", alu_seen); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL div_idle got=%b exp=0", busy); end
    total++; if (lo !== 32'd3) begin bad++; $display("FAIL div_lo got=%h exp=00000003", lo); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL div_hi got=%h exp=00000002", hi); end
  endtask

  task automatic test_illegal();
    IR = 32'h0000_0000;
    mem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_pulse got=%b exp=1", illegal); end
    total++; if (Rout !== 16'h0) begin bad++; $display("FAIL ill_rout got=%h exp=0000", Rout); end
    total++; if (Yin !== 1'b0) begin bad++; $display("FAIL ill_yin got=%b exp=0", Yin); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ill_done got=%b exp=0", done); end
    tick();
    total++; if (stat !== 4'b0000) begin bad++; $display("FAIL ill_after got=%b exp=0000", stat); end
  endtask

  task automatic test_timeout();
    int   t1 = 0;
    logic err_in_t1 = 1'b0;
    IR = 32'h7B380000;
    mem_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      if (!Read) break;
      t1++;
      if (mem_err) err_in_t1 = 1'b1;
      tick();
    end
    total++; if (t1 != 8) begin bad++; $display("FAIL to_t1_cycles got=%0d exp=8", t1); end
    total++; if (stat !== 4'b0001) begin bad++; $display("FAIL to_err_stat got=%b exp=0001", stat); end
    total++; if (err_in_t1 !== 1'b0) begin bad++; $display("FAIL to_err_early got=%b exp=0", err_in_t1); end
    tick();
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL to_err_width got=%b exp=0", mem_err); end

    t1 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      if (!Read) break;
      t1++;
      if (t1 == 8) mem_ready = 1'b1;
      tick();
    end
    total++; if (t1 != 8) begin bad++; $display("FAIL to_late_t1 got=%0d exp=8", t1); end
    total++; if (ctl !== 16'h00C0) begin bad++; $display("FAIL to_late_t2 got=%h exp=00c0", ctl); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL to_late_err got=%b exp=0", mem_err); end
    for (int k = 0; k < 10; k++) begin
      if (done) break;
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL to_late_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int drops = 0;
    IR = 32'h7B380000;
    mem_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int s = 1; s <= 14; s++) begin
      if (!busy) drops++;
      if (done) dones++;
      if (s == 8) begin
        total++; if (ctl !== 16'hF000) begin bad++; $display("FAIL b2b_t0 got=%h exp=f000", ctl); end
        start = 1'b0;
      end
      tick();
    end
    total++; if (dones != 2) begin bad++; $display("FAIL b2b_dones got=%0d exp=2", dones); end
    total++; if (drops != 0) begin bad++; $display("FAIL b2b_drops got=%0d exp=0", drops); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    total++; if (lo !== 32'h3C) begin bad++; $display("FAIL b2b_lo got=%h exp=0000003c", lo); end
  endtask

  task automatic test_reset_mid();
    IR = 32'h7B380000;
    mem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    total++; if (ctl !== 16'h0018) begin bad++; $display("FAIL rst_mid_t4 got=%h exp=0018", ctl); end
    #2 clr = 1'b0;
    #1;
    total++; if (ctl !== 16'h0000) begin bad++; $display("FAIL rst_mid_ctl got=%h exp=0000", ctl); end
    total++; if (Rout !== 16'h0000) begin bad++; $display("FAIL rst_mid_rout got=%h exp=0000", Rout); end
    total++; if (ALU_opcode !== 5'b0) begin bad++; $display("FAIL rst_mid_alu got=%b exp=00000", ALU_opcode); end
    total++; if (stat !== 4'b0000) begin bad++; $display("FAIL rst_mid_stat got=%b exp=0000", stat); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_nodone got=%b exp=0", done); end
    clr = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (ctl !== 16'hF000) begin bad++; $display("FAIL rst_restart_t0 got=%h exp=f000", ctl); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_restart_busy got=%b exp=1", busy); end
    for (int k = 0; k < 12; k++) begin
      if (done) break;
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rst_restart_done got=%b exp=1", done); end
    tick();
  endtask

  initial begin
    clr = 1'b0;
    start = 1'b0;
    mem_ready = 1'b0;
    IR = '0;
    for (int i = 0; i < 16; i++) rf[i] = 32'(i) * 32'd16;
    rf[2] = 32'd17;
    rf[3] = 32'd5;
    rf[6] = 32'hF;
    rf[7] = 32'h4;
    test_reset();
    test_mul();
    test_div();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
